// File: rtl/rx_symb_scheduler.sv
// rx_symb_scheduler: tags RMSP symbols with {frame, symbol index}, launches FFT loads and
// re-attaches tags at the FFT output. Optional error counters: define RX_SCHED_ERR_CNT_EN.
module rx_symb_scheduler #(
    parameter int FRAME_W = 7,
    parameter int SYMB_W  = 4,
    parameter int DEPTH   = 4,
    parameter int N_FFT   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rmsp_sop,
    input  logic [FRAME_W-1:0] frame_count_in,
    input  logic               fft_in_ready,
    output logic               buf_rd_start,
    input  logic               fft_sop,
    output logic               tag_valid,
    output logic [FRAME_W-1:0] frame_count_out,
    output logic [SYMB_W-1:0]  symb_idx_out,
    output logic               busy,
    input  logic               err_clr,
    output logic               ovf_flag,
    output logic               udf_flag
`ifdef RX_SCHED_ERR_CNT_EN
    ,
    output logic [15:0]        ovf_cnt,
    output logic [15:0]        udf_cnt
`endif
);

    localparam int TAG_W = FRAME_W + SYMB_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = (N_FFT > 1) ? $clog2(N_FFT) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t             state_r;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic               buf_rd_start_r;
    logic               busy_r;

    logic [TAG_W-1:0]   pend_mem_r [DEPTH];
    logic [PTR_W-1:0]   pend_rd_ptr_r;
    logic [PTR_W-1:0]   pend_wr_ptr_r;
    logic [CNT_W-1:0]   pend_cnt_r;

    logic [TAG_W-1:0]   infl_mem_r [DEPTH];
    logic [PTR_W-1:0]   infl_rd_ptr_r;
    logic [PTR_W-1:0]   infl_wr_ptr_r;
    logic [CNT_W-1:0]   infl_cnt_r;

    logic               first_r;
    logic [FRAME_W-1:0] last_frame_r;
    logic [SYMB_W-1:0]  last_idx_r;

    logic               tag_valid_r;
    logic [FRAME_W-1:0] frame_out_r;
    logic [SYMB_W-1:0]  idx_out_r;
    logic               ovf_flag_r;
    logic               udf_flag_r;

    logic               pend_empty_s;
    logic               pend_full_s;
    logic               infl_empty_s;
    logic               infl_full_s;
    logic               launch_s;
    logic               pend_push_s;
    logic               infl_pop_s;
    logic               ovf_evt_s;
    logic               udf_evt_s;
    logic [SYMB_W-1:0]  new_idx_s;

    assign pend_empty_s = (pend_cnt_r == {CNT_W{1'b0}});
    assign pend_full_s  = (pend_cnt_r == CNT_W'(DEPTH));
    assign infl_empty_s = (infl_cnt_r == {CNT_W{1'b0}});
    assign infl_full_s  = (infl_cnt_r == CNT_W'(DEPTH));

    // A full in-flight queue does not block a launch when fft_sop frees a slot this cycle.
    assign launch_s    = (state_r == ST_IDLE) && !pend_empty_s && fft_in_ready &&
                         (!infl_full_s || fft_sop);
    assign pend_push_s = rmsp_sop && (!pend_full_s || launch_s);
    assign ovf_evt_s   = rmsp_sop && pend_full_s && !launch_s;
    assign infl_pop_s  = fft_sop && !infl_empty_s;
    assign udf_evt_s   = fft_sop && infl_empty_s;

    // Symbol index restarts on the first symbol and on every frame number change.
    always_comb begin
        new_idx_s = {SYMB_W{1'b0}};
        if (first_r || (frame_count_in != last_frame_r)) begin
            new_idx_s = {SYMB_W{1'b0}};
        end else begin
            new_idx_s = last_idx_r + SYMB_W'(1);
        end
    end

    // Index tracker advances even when the tag itself is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_r      <= 1'b1;
            last_frame_r <= {FRAME_W{1'b0}};
            last_idx_r   <= {SYMB_W{1'b0}};
        end else if (rmsp_sop) begin
            first_r      <= 1'b0;
            last_frame_r <= frame_count_in;
            last_idx_r   <= new_idx_s;
        end else begin
            first_r      <= first_r;
        end
    end

    // Load state machine with its registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cyc_cnt_r      <= {CYC_W{1'b0}};
            buf_rd_start_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_r        <= ST_LOAD;
                        cyc_cnt_r      <= CYC_W'(N_FFT - 1);
                        buf_rd_start_r <= 1'b1;
                        busy_r         <= 1'b1;
                    end else begin
                        buf_rd_start_r <= 1'b0;
                        busy_r         <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    buf_rd_start_r <= 1'b0;
                    if (cyc_cnt_r == {CYC_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r - CYC_W'(1);
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    cyc_cnt_r      <= {CYC_W{1'b0}};
                    buf_rd_start_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    // Pending tag queue: filled by rmsp_sop, drained by each launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_mem_r[i] <= {TAG_W{1'b0}};
            end
            pend_rd_ptr_r <= {PTR_W{1'b0}};
            pend_wr_ptr_r <= {PTR_W{1'b0}};
            pend_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (pend_push_s) begin
                pend_mem_r[pend_wr_ptr_r] <= {frame_count_in, new_idx_s};
                pend_wr_ptr_r             <= pend_wr_ptr_r + PTR_W'(1);
            end
            if (launch_s) begin
                pend_rd_ptr_r <= pend_rd_ptr_r + PTR_W'(1);
            end
            pend_cnt_r <= pend_cnt_r + CNT_W'(pend_push_s) - CNT_W'(launch_s);
        end
    end

    // In-flight tag queue: filled on launch, drained by fft_sop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                infl_mem_r[i] <= {TAG_W{1'b0}};
            end
            infl_rd_ptr_r <= {PTR_W{1'b0}};
            infl_wr_ptr_r <= {PTR_W{1'b0}};
            infl_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (launch_s) begin
                infl_mem_r[infl_wr_ptr_r] <= pend_mem_r[pend_rd_ptr_r];
                infl_wr_ptr_r             <= infl_wr_ptr_r + PTR_W'(1);
            end
            if (infl_pop_s) begin
                infl_rd_ptr_r <= infl_rd_ptr_r + PTR_W'(1);
            end
            infl_cnt_r <= infl_cnt_r + CNT_W'(launch_s) - CNT_W'(infl_pop_s);
        end
    end

    // Output tag register; holds its value across an underflowing fft_sop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= 1'b0;
            frame_out_r <= {FRAME_W{1'b0}};
            idx_out_r   <= {SYMB_W{1'b0}};
        end else if (infl_pop_s) begin
            tag_valid_r              <= 1'b1;
            {frame_out_r, idx_out_r} <= infl_mem_r[infl_rd_ptr_r];
        end else begin
            tag_valid_r <= 1'b0;
        end
    end

    // Sticky error flags; a new event overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag_r <= 1'b0;
            udf_flag_r <= 1'b0;
        end else begin
            ovf_flag_r <= ovf_evt_s | (ovf_flag_r & ~err_clr);
            udf_flag_r <= udf_evt_s | (udf_flag_r & ~err_clr);
        end
    end

`ifdef RX_SCHED_ERR_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] ovf_cnt_r;
    logic [15:0] udf_cnt_r;

    // Saturating error counters; an event coinciding with a clear counts as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= 16'd0;
            udf_cnt_r <= 16'd0;
        end else begin
            if (ovf_evt_s) begin
                ovf_cnt_r <= err_clr ? 16'd1 : sat_inc(ovf_cnt_r);
            end else if (err_clr) begin
                ovf_cnt_r <= 16'd0;
            end else begin
                ovf_cnt_r <= ovf_cnt_r;
            end
            if (udf_evt_s) begin
                udf_cnt_r <= err_clr ? 16'd1 : sat_inc(udf_cnt_r);
            end else if (err_clr) begin
                udf_cnt_r <= 16'd0;
            end else begin
                udf_cnt_r <= udf_cnt_r;
            end
        end
    end

    assign ovf_cnt = ovf_cnt_r;
    assign udf_cnt = udf_cnt_r;
`endif

    assign buf_rd_start    = buf_rd_start_r;
    assign busy            = busy_r;
    assign tag_valid       = tag_valid_r;
    assign frame_count_out = frame_out_r;
    assign symb_idx_out    = idx_out_r;
    assign ovf_flag        = ovf_flag_r;
    assign udf_flag        = udf_flag_r;

endmodule

// File: tb/tb_rx_symb_scheduler.sv
// Scoreboard bench for rx_symb_scheduler: a queue-based reference model predicts every
// cycle's outputs; a negedge monitor pops and compares. Honours RX_SCHED_ERR_CNT_EN.
module tb_rx_symb_scheduler;

    localparam int FRAME_W = 7;
    localparam int SYMB_W  = 4;
    localparam int DEPTH   = 4;
    localparam int N_FFT   = 256;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rmsp_sop = 1'b0;
    logic [FRAME_W-1:0] frame_count_in = '0;
    logic               fft_in_ready = 1'b0;
    logic               fft_sop = 1'b0;
    logic               err_clr = 1'b0;
    logic               buf_rd_start, tag_valid, busy, ovf_flag, udf_flag;
    logic [FRAME_W-1:0] frame_count_out;
    logic [SYMB_W-1:0]  symb_idx_out;
`ifdef RX_SCHED_ERR_CNT_EN
    logic [15:0]        ovf_cnt, udf_cnt;
`endif

    rx_symb_scheduler #(.FRAME_W(FRAME_W), .SYMB_W(SYMB_W), .DEPTH(DEPTH), .N_FFT(N_FFT)) dut (
        .clk(clk), .rst_n(rst_n), .rmsp_sop(rmsp_sop), .frame_count_in(frame_count_in),
        .fft_in_ready(fft_in_ready), .buf_rd_start(buf_rd_start), .fft_sop(fft_sop),
        .tag_valid(tag_valid), .frame_count_out(frame_count_out), .symb_idx_out(symb_idx_out),
        .busy(busy), .err_clr(err_clr), .ovf_flag(ovf_flag), .udf_flag(udf_flag)
`ifdef RX_SCHED_ERR_CNT_EN
        , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic       brs, bsy, tv, ovf, udf;
        logic [6:0] fr;
        logic [3:0] ix;
        int         oc, uc;
    } st_t;

    st_t         st_q[$];
    logic [10:0] pend_q[$];
    logic [10:0] infl_q[$];
    logic [10:0] tag_q[$];

    bit         m_first;
    logic [6:0] m_last_fr;
    logic [3:0] m_last_ix;
    int         m_next_ok, m_last_d, m_oc, m_uc;
    bit         m_ovf, m_udf;
    logic [6:0] m_ofr;
    logic [3:0] m_oix;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        st_q.delete(); pend_q.delete(); infl_q.delete(); tag_q.delete();
        m_first = 1'b1; m_last_fr = '0; m_last_ix = '0;
        m_next_ok = 0; m_last_d = -100000;
        m_ovf = 1'b0; m_udf = 1'b0; m_ofr = '0; m_oix = '0; m_oc = 0; m_uc = 0;
    endtask

    // Predict the outputs visible in cycle c+1 from the inputs applied in cycle c.
    task automatic model_step(input int c, input bit sop, input logic [6:0] fr,
                              input bit rdy, input bit fsop, input bit eclr);
        bit          launch, oe, ue, tv;
        logic [10:0] lt, ot;
        logic [3:0]  ix;
        st_t         e;
        launch = (c >= m_next_ok) && (pend_q.size() > 0) && rdy &&
                 ((infl_q.size() < DEPTH) || fsop);
        oe = 1'b0; ue = 1'b0; tv = 1'b0; lt = '0;
        if (launch) begin
            lt = pend_q.pop_front();
            m_last_d  = c;
            m_next_ok = c + N_FFT + 1;
        end
        if (fsop) begin
            if (infl_q.size() == 0) ue = 1'b1;
            else begin
                ot = infl_q.pop_front();
                tag_q.push_back(ot);
                tv = 1'b1;
                m_ofr = ot[10:4]; m_oix = ot[3:0];
            end
        end
        if (launch) infl_q.push_back(lt);
        if (sop) begin
            ix = (m_first || fr != m_last_fr) ? 4'd0 : 4'(m_last_ix + 4'd1);
            m_first = 1'b0; m_last_fr = fr; m_last_ix = ix;
            if (pend_q.size() < DEPTH) pend_q.push_back({fr, ix});
            else oe = 1'b1;
        end
        m_ovf = oe || (m_ovf && !eclr);
        m_udf = ue || (m_udf && !eclr);
        if (eclr) begin m_oc = 0; m_uc = 0; end
        if (oe && m_oc < 65535) m_oc++;
        if (ue && m_uc < 65535) m_uc++;
        e.cyc = c + 1; e.brs = launch; e.tv = tv; e.ovf = m_ovf; e.udf = m_udf;
        e.bsy = (c + 1 > m_last_d) && (c + 1 <= m_last_d + N_FFT);
        e.fr = m_ofr; e.ix = m_oix; e.oc = m_oc; e.uc = m_uc;
        st_q.push_back(e);
    endtask

    task automatic step(input bit sop, input logic [6:0] fr, input bit rdy,
                        input bit fsop, input bit eclr);
        rmsp_sop = sop; frame_count_in = fr; fft_in_ready = rdy; fft_sop = fsop; err_clr = eclr;
        model_step(cyc, sop, fr, rdy, fsop, eclr);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, frame_count_in, rdy, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, frame_count_in, 1'b0, 1'b1, 1'b0);
            idle(2, 1'b0);
        end
    endtask

    // Monitor: per-cycle expectations plus tag payload on every tag_valid.
    always @(negedge clk) begin
        st_t         e;
        logic [10:0] t;
        if (rst_n) begin
            while (st_q.size() > 0 && st_q[0].cyc < cyc) e = st_q.pop_front();
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                e = st_q.pop_front();
                chk("buf_rd_start", 32'(buf_rd_start), 32'(e.brs));
                chk("busy", 32'(busy), 32'(e.bsy));
                chk("tag_valid", 32'(tag_valid), 32'(e.tv));
                chk("ovf_flag", 32'(ovf_flag), 32'(e.ovf));
                chk("udf_flag", 32'(udf_flag), 32'(e.udf));
                chk("frame_out_hold", 32'(frame_count_out), 32'(e.fr));
                chk("idx_out_hold", 32'(symb_idx_out), 32'(e.ix));
`ifdef RX_SCHED_ERR_CNT_EN
                chk("ovf_cnt", 32'(ovf_cnt), 32'(e.oc));
                chk("udf_cnt", 32'(udf_cnt), 32'(e.uc));
`endif
            end
            if (tag_valid) begin
                if (tag_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tag_unexpected cyc=%0d actual=(%0d,%0d) required=none",
                             cyc, frame_count_out, symb_idx_out);
                end else begin
                    t = tag_q.pop_front();
                    chk("tag_frame", 32'(frame_count_out), 32'(t[10:4]));
                    chk("tag_idx", 32'(symb_idx_out), 32'(t[3:0]));
                end
            end
        end
    end

    initial begin
        logic [6:0] rf;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_buf_rd_start", 32'(buf_rd_start), 32'd0);
        chk("rst_tag_valid", 32'(tag_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf_flag), 32'd0);
        chk("rst_udf", 32'(udf_flag), 32'd0);
        chk("rst_frame_out", 32'(frame_count_out), 32'd0);
        chk("rst_idx_out", 32'(symb_idx_out), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();

        // Frame 5 x3 then frame 6: expect (5,0) (5,1) (5,2) (6,0).
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'd5, 1'b1, 1'b0, 1'b0);
            step(1'b0, 7'd5, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 7'd6, 1'b1, 1'b0, 1'b0);
        idle(4 * (N_FFT + 1) + 4, 1'b1);
        drain(4);

        // Five symbols with FFT not ready: fifth dropped, then four spaced launches.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 7'd9, 1'b0, 1'b0, 1'b0);
            step(1'b0, 7'd9, 1'b0, 1'b0, 1'b0);
        end
        idle(4 * (N_FFT + 1) + 4, 1'b1);
        drain(4);
        step(1'b0, 7'd9, 1'b0, 1'b0, 1'b1);

        // Underflow, clear, then clear colliding with a new underflow.
        drain(1);
        step(1'b0, 7'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, 7'd9, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0);
        step(1'b0, 7'd9, 1'b0, 1'b0, 1'b1);

        // Full pending queue with a push in the launch cycle: no drop.
        for (int i = 0; i < 4; i++) step(1'b1, 7'd11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'd12, 1'b1, 1'b0, 1'b0);
        idle(4 * (N_FFT + 1) + 4, 1'b1);
        drain(4);

        // Reset in the middle of the second LOAD with two tags in flight.
        step(1'b1, 7'd20, 1'b1, 1'b0, 1'b0);
        step(1'b1, 7'd20, 1'b1, 1'b0, 1'b0);
        idle(N_FFT + 20, 1'b1);
        chk("busy_before_rst", 32'(busy), 32'd1);
        rmsp_sop = 1'b0; fft_in_ready = 1'b0; fft_sop = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_buf_rd_start", 32'(buf_rd_start), 32'd0);
        chk("midrst_tag_valid", 32'(tag_valid), 32'd0);
        chk("midrst_frame_out", 32'(frame_count_out), 32'd0);
        chk("midrst_idx_out", 32'(symb_idx_out), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain(1);

        // Randomised traffic.
        rf = 7'd30;
        for (int i = 0; i < 4000; i++) begin
            bit s;
            s = ($urandom_range(0, 29) == 0);
            if (s && $urandom_range(0, 3) == 0) rf = rf + 7'd1;
            step(s, rf, 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        idle(4, 1'b0);

`ifdef RX_SCHED_ERR_CNT_EN
        // Saturate the overflow counter.
        step(1'b0, rf, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, rf, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b1, rf, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("ovf_cnt_saturated", 32'(ovf_cnt), 32'h0000FFFF);
`endif

        idle(3, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_symb_scheduler.md
# rx_symb_scheduler

Receive-path scheduler between the RMSP (CP-removal / symbol buffer) stage and the FFT core. Queues each symbol announced by `rmsp_sop` with its frame number and intra-frame symbol index. Launches symbol-buffer reads into the FFT only when the FFT is ready and tag capacity exists. Re-attaches the matching frame/symbol tag when the symbol emerges at the FFT output (`fft_sop`). Reports queue overflow and underflow.

## Interface
- `FRAME_W`, 7: frame counter width.
- `SYMB_W`, 4: intra-frame symbol index width.
- `DEPTH`, 4: entries in each tag queue; power of two, ≥2.
- `N_FFT`, 256: cycles one symbol load into the FFT occupies.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rmsp_sop`  in  1  one-cycle pulse: a new symbol is stored in the RMSP buffer.
- `frame_count_in`  in  FRAME_W  frame number, valid with `rmsp_sop`.
- `fft_in_ready`  in  1  FFT can accept a new input symbol.
- `buf_rd_start`  out  1  one-cycle pulse: RMSP buffer starts streaming one symbol into the FFT.
- `fft_sop`  in  1  one-cycle pulse: first sample of a transformed symbol at the FFT output.
- `tag_valid`  out  1  one-cycle pulse: `frame_count_out` and `symb_idx_out` are updated.
- `frame_count_out`  out  FRAME_W  frame number of the current FFT output symbol.
- `symb_idx_out`  out  SYMB_W  symbol index of the current FFT output symbol.
- `busy`  out  1  load state machine is in LOAD.
- `err_clr`  in  1  synchronous clear of error flags and counters.
- `ovf_flag`  out  1  sticky: `rmsp_sop` was dropped because the pending queue was full.
- `udf_flag`  out  1  sticky: `fft_sop` arrived while the in-flight queue was empty.

## Operation
- **Symbol indexing**
  - On `rmsp_sop`, a registered `last_frame` and a first-symbol flag are compared with `frame_count_in`.
  - First symbol after reset, or a frame number change: index = 0.
  - Otherwise: index = previous index + 1, wrapping modulo 2^SYMB_W.
  - Tag {frame, index} is pushed to the pending queue.
- **Pending queue** (DEPTH entries)
  - Push on `rmsp_sop`; pop on `buf_rd_start`.
  - Push and pop in the same cycle are always accepted, including when the queue is full.
  - Push while full without a simultaneous pop: tag is dropped, `ovf_flag` is set, and the index counter still advances.
- **Load FSM**
  - States are IDLE and LOAD.
  - IDLE→LOAD when all of the following hold in the same cycle:
    - pending queue is non-empty;
    - `fft_in_ready` = 1;
    - in-flight queue is not full, or `fft_sop` pops it in that cycle.
  - The transition cycle registers `buf_rd_start` = 1 for the next cycle, moves the head tag from pending to in-flight, and loads the cycle counter with N_FFT−1.
  - In LOAD the counter decrements each cycle; at 0 the FSM returns to IDLE.
  - Back-to-back loads are possible with a 1-cycle IDLE gap.
- **In-flight queue** (DEPTH entries)
  - Push on launch; pop on `fft_sop`.
  - Pop: head tag is registered to the outputs and `tag_valid` pulses.
  - `fft_sop` with the queue empty: `udf_flag` is set, outputs hold their value, and no `tag_valid` pulse is issued.
- `err_clr` clears the flags (and counters, see Configuration). A simultaneous error event wins: the flag stays set.

## Timing
- Reset values:
  - `buf_rd_start`, `tag_valid`, `busy`, `ovf_flag`, `udf_flag` = 0.
  - `frame_count_out`, `symb_idx_out` = 0.
  - Queues empty, FSM in IDLE, first-symbol flag set.
- Reset mid-LOAD: abort immediately. In-flight tags are discarded, so the next `fft_sop` is an underflow.
- `rmsp_sop` at cycle t: the tag is eligible for launch at t+1; earliest `buf_rd_start` is at t+2.
- `fft_sop` at cycle t: `tag_valid`, `frame_count_out`, `symb_idx_out` update at t+1.
- `busy` = 1 from the `buf_rd_start` cycle through the following N_FFT−1 cycles.
- `fft_in_ready` is sampled only in IDLE. Deassertion during LOAD has no effect.

## Configuration
- `RX_SCHED_ERR_CNT_EN` defined:
  - adds outputs `ovf_cnt[15:0]` and `udf_cnt[15:0]`;
  - each counter increments on the corresponding error event and saturates at 16'hFFFF;
  - cleared by reset and by `err_clr`.
- Not defined: the ports and counters are absent; only the sticky flags exist.

## Test plan
- Three `rmsp_sop` pulses with frame 5, then one with frame 6, `fft_in_ready`=1, then four `fft_sop` -> tag_valid ×4 with (5,0), (5,1), (5,2), (6,0).
- Five `rmsp_sop` pulses, DEPTH=4, `fft_in_ready`=0 -> `ovf_flag`=1. Then enable ready -> exactly four `buf_rd_start` pulses, each N_FFT+1 cycles apart.
- `fft_sop` with nothing in flight -> `udf_flag`=1, no `tag_valid`, outputs unchanged. Then `err_clr` -> flag = 0.
- Pending queue full, with `rmsp_sop` coinciding with a launch -> no overflow, and the new tag is kept.
- `rst_n` low during LOAD, with two tags in flight -> all outputs 0 immediately; the following `fft_sop` sets `udf_flag`.
- With `RX_SCHED_ERR_CNT_EN` defined: 70000 overflow events -> `ovf_cnt`=16'hFFFF.
